aes_v3_round_seq: RTL



---
 rtl/aes_v3_pkg.sv | 49 ++++
 rtl/aes_sbox.sv | 19 +
 rtl/aes_v3_byte_lane.sv | 26 ++
 rtl/aes_v3_round_seq.sv | 110 +++++++++++
 4 files changed

// File: rtl/aes_v3_pkg.sv
// Shared types, constants and GF(2^8) helpers for the v3 AES round sequencer.
package aes_v3_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_e;

  localparam int COL_W = 2;
  localparam int ROW_W = 2;

  localparam logic [7:0] GF_RED = 8'h1b;
  localparam logic [7:0] MIX_2  = 8'd2;
  localparam logic [7:0] MIX_3  = 8'd3;
  localparam logic [7:0] MIX_9  = 8'd9;
  localparam logic [7:0] MIX_B  = 8'd11;
  localparam logic [7:0] MIX_D  = 8'd13;
  localparam logic [7:0] MIX_E  = 8'd14;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_RED : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse, with 0 mapping to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int b = 7; b >= 0; b--) begin
      r = gf_mul(r, r);
      if (b != 0) r = gf_mul(r, a);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box / inverse S-box from the GF inverse and affine map.
module aes_sbox
  import aes_v3_pkg::*;
(
  input  logic [7:0] in_i,
  input  logic       dec_i,
  output logic [7:0] out_o
);

  logic [7:0] fwd, inv_aff;

  always_comb begin
    fwd     = gf_inv(in_i);
    fwd     = fwd ^ rotl8(fwd, 1) ^ rotl8(fwd, 2) ^ rotl8(fwd, 3) ^ rotl8(fwd, 4) ^ 8'h63;
    inv_aff = rotl8(in_i, 1) ^ rotl8(in_i, 3) ^ rotl8(in_i, 6) ^ 8'h05;
    out_o   = dec_i ? gf_inv(inv_aff) : fwd;
  end

endmodule

// File: rtl/aes_v3_byte_lane.sv
// One byte lane: S-box, (Inv)MixColumns column contribution, rotate to its row.
module aes_v3_byte_lane
  import aes_v3_pkg::*;
(
  input  logic [7:0]       byte_i,
  input  logic             dec_i,
  input  logic             mix_i,
  input  logic [ROW_W-1:0] row_i,
  output logic [31:0]      contrib_o
);

  logic [7:0]  s;
  logic [31:0] w;
  logic [5:0]  sh;

  aes_sbox u_sbox (.in_i(byte_i), .dec_i(dec_i), .out_o(s));

  always_comb begin
    if (!mix_i)     w = {24'b0, s};
    else if (dec_i) w = {gf_mul(s, MIX_B), gf_mul(s, MIX_D), gf_mul(s, MIX_9), gf_mul(s, MIX_E)};
    else            w = {gf_mul(s, MIX_3), s, s, gf_mul(s, MIX_2)};
    sh        = {1'b0, row_i, 3'b000};
    contrib_o = (w << sh) | (w >> (6'd32 - sh));
  end

endmodule

// File: rtl/aes_v3_round_seq.sv
// Multi-cycle AES round engine. Define AES_V3_SEQ_QUAD_SBOX_EN for four lanes
// (one output column per step, 4 steps) instead of one lane over 16 steps.
module aes_v3_round_seq
  import aes_v3_pkg::*;
(
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_dec,
  input  logic         req_mix,
  input  logic [127:0] req_state,
  input  logic [127:0] req_rkey,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_state
);

`ifdef AES_V3_SEQ_QUAD_SBOX_EN
  localparam int NLANES = 4;
`else
  localparam int NLANES = 1;
`endif
  localparam logic [3:0] LAST = 4'(16 / NLANES - 1);

  state_e         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   din_q, din_d, acc_q, acc_d;
  logic           dec_q, dec_d, mix_q, mix_d;

  logic [COL_W-1:0]              col_j;
  logic [NLANES-1:0][ROW_W-1:0]  lane_row;
  logic [NLANES-1:0][7:0]        lane_byte;
  logic [NLANES-1:0][31:0]       lane_out;
  logic [31:0]                   contrib;

  // Quad build walks columns with the counter; single lane walks column-major.
  assign col_j = (NLANES == 4) ? cnt_q[1:0] : cnt_q[3:2];

  for (genvar g = 0; g < NLANES; g++) begin : g_lane
    logic [COL_W-1:0] src_c;
    assign lane_row[g]  = (NLANES == 4) ? 2'(g) : cnt_q[1:0];
    assign src_c        = dec_q ? col_j - lane_row[g] : col_j + lane_row[g];
    assign lane_byte[g] = din_q[{src_c, lane_row[g], 3'b000} +: 8];
    aes_v3_byte_lane u_lane (
      .byte_i    (lane_byte[g]),
      .dec_i     (dec_q),
      .mix_i     (mix_q),
      .row_i     (lane_row[g]),
      .contrib_o (lane_out[g])
    );
  end

  always_comb begin
    contrib = '0;
    for (int g = 0; g < NLANES; g++) contrib = contrib ^ lane_out[g];
  end

  assign req_ready = (state_q == ST_IDLE) && !g_reset;
  assign rsp_valid = (state_q == ST_DONE);
  assign rsp_state = acc_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    acc_d   = acc_q;
    dec_d   = dec_q;
    mix_d   = mix_q;
    case (state_q)
      ST_IDLE: if (req_valid && req_ready) begin
        din_d   = req_state;
        acc_d   = req_rkey;
        dec_d   = req_dec;
        mix_d   = req_mix;
        cnt_d   = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        acc_d[{col_j, 5'b00000} +: 32] = acc_q[{col_j, 5'b00000} +: 32] ^ contrib;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      din_q   <= '0;
      acc_q   <= '0;
      dec_q   <= 1'b0;
      mix_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      acc_q   <= acc_d;
      dec_q   <= dec_d;
      mix_q   <= mix_d;
    end
  end

endmodule
